// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: multiple outstanding icache requests, stale-response
// discard after redirect, ADEF on misaligned PCs, and a small instruction FIFO feeding ID.
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC        = 32'h1c000000,
   parameter int          MAX_OUTSTANDING = 4,
   parameter int          QUEUE_DEPTH     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        fetch_hold,
   output logic        inst_valid,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        fs_to_ds_valid,
   input  logic        ds_allowin,
   output logic [31:0] fs_inst,
   output logic [31:0] fs_pc,
   output logic        fs_excp
);
   localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int QPW = $clog2(QUEUE_DEPTH);
   localparam int OCW = $clog2(MAX_OUTSTANDING) + 1;
   localparam int QCW = QPW + 1;
   localparam logic [OCW-1:0] MAX_OUT = OCW'(MAX_OUTSTANDING);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        excp;
   } entry_t;

   logic [31:0]    pc;
   logic [OCW-1:0] outstanding;
   logic [OCW-1:0] discard;
   logic           adef_pend;
   logic [31:0]    tag_mem [2**TPW];
   logic [TPW-1:0] tag_rd;
   logic [TPW-1:0] tag_wr;
   entry_t         q_mem [QUEUE_DEPTH];
   logic [QPW-1:0] q_rd;
   logic [QPW-1:0] q_wr;
   logic [QCW-1:0] q_count;

   logic [31:0] nextpc;
   logic        head_valid;
   logic        deq;
   logic        misaligned;
   logic        adef_block;
   logic        adef_fire;
   logic        issue;
   logic        resp_live;
   logic        push;
   int          credit_live;
   int          credit_q;
   int          occupancy;
   entry_t      head;
   entry_t      push_entry;

   assign nextpc         = redirect_valid ? redirect_pc : pc;
   assign inst_addr      = nextpc;
   assign head           = q_mem[q_rd];
   assign head_valid     = (q_count != '0);
   assign fs_to_ds_valid = head_valid && !redirect_valid && !reset;
   assign deq            = fs_to_ds_valid && ds_allowin;
   assign fs_pc          = head_valid ? head.pc : 32'h0;
   assign fs_inst        = head_valid ? head.inst : 32'h0;
   assign fs_excp        = head_valid && head.excp;

   // A redirect kills everything in flight and queued, so the new stream sees full credit.
   assign credit_live = redirect_valid ? 0 : int'(outstanding - discard);
   assign credit_q    = redirect_valid ? 0 : int'(q_count);
   assign occupancy   = credit_live + credit_q - int'(deq);

   assign misaligned = (nextpc[1:0] != 2'b00);
   assign adef_block = adef_pend && !redirect_valid;
   assign adef_fire  = !reset && misaligned && !adef_block && (credit_live == 0)
                       && ((credit_q - int'(deq)) < QUEUE_DEPTH);
   assign inst_valid = !reset && !fetch_hold && !adef_block && !misaligned
                       && (outstanding < MAX_OUT) && (occupancy < QUEUE_DEPTH);
   assign issue      = inst_valid && inst_addr_ok;
   assign resp_live  = inst_data_ok && !redirect_valid && (discard == '0);
   assign push       = resp_live || adef_fire;

   // With live==0 any response this cycle is stale, so ADEF and a live push never collide.
   // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
   always_comb begin
      push_entry = '{pc: tag_mem[tag_rd], inst: inst_rdata, excp: 1'b0};
      if (adef_fire) push_entry = '{pc: nextpc, inst: 32'h0, excp: 1'b1};
   end

   // NOTE: registers use non-blocking assignments so every update reads pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         adef_pend   <= 1'b0;
         tag_rd      <= '0;
         tag_wr      <= '0;
         q_rd        <= '0;
         q_wr        <= '0;
         q_count     <= '0;
      end else begin
         pc          <= issue ? nextpc + 32'd4 : nextpc;
         outstanding <= outstanding + OCW'(issue) - OCW'(inst_data_ok);
         if (issue)        tag_wr <= tag_wr + TPW'(1);
         if (inst_data_ok) tag_rd <= tag_rd + TPW'(1);
         if (push)         q_wr   <= q_wr + QPW'(1);
         if (redirect_valid) begin
            discard   <= outstanding - OCW'(inst_data_ok);
            adef_pend <= adef_fire;
            q_rd      <= q_wr;
            q_count   <= QCW'(push);
         end else begin
            if (inst_data_ok && (discard != '0)) discard <= discard - OCW'(1);
            if (adef_fire) adef_pend <= 1'b1;
            if (deq)       q_rd      <= q_rd + QPW'(1);
            q_count <= q_count + QCW'(push) - QCW'(deq);
         end
      end
   end

   // NOTE: storage arrays have no reset; pointers and counts alone define valid contents.
   always_ff @(posedge clk) begin
      if (issue) tag_mem[tag_wr] <= nextpc;
      if (push)  q_mem[q_wr]     <= push_entry;
   end

   assert property (@(posedge clk) disable iff (reset) inst_data_ok |-> (outstanding != '0));
   assert property (@(posedge clk) disable iff (reset) discard <= outstanding);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: in-order icache model plus a scoreboard of the
// instructions ID must receive, flushed on every redirect.
module tb_if_fetch_queue;
   localparam logic [31:0] RESET_PC = 32'h1c000000;
   localparam int          QD       = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_hold;
   logic        inst_valid;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        fs_to_ds_valid;
   logic        ds_allowin;
   logic [31:0] fs_inst;
   logic [31:0] fs_pc;
   logic        fs_excp;

   always #5 clk = ~clk;

   if_fetch_queue #(.RESET_PC(RESET_PC), .MAX_OUTSTANDING(4), .QUEUE_DEPTH(QD)) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_hold     (fetch_hold),
      .inst_valid     (inst_valid),
      .inst_addr      (inst_addr),
      .inst_addr_ok   (inst_addr_ok),
      .inst_data_ok   (inst_data_ok),
      .inst_rdata     (inst_rdata),
      .fs_to_ds_valid (fs_to_ds_valid),
      .ds_allowin     (ds_allowin),
      .fs_inst        (fs_inst),
      .fs_pc          (fs_pc),
      .fs_excp        (fs_excp)
   );

   typedef struct { logic [31:0] pc; logic [31:0] inst; logic excp; } exp_t;
   typedef struct { logic [31:0] addr; int due; } req_t;

   exp_t        exp_q[$];
   req_t        req_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          last_due = 0;
   int          lat_min = 2;
   int          lat_max = 2;
   bit          rand_ok = 1'b0;
   int          pops = 0;
   int          adef_seen = 0;
   logic [31:0] first_pc;
   logic [31:0] last_pc;
   logic [31:0] model_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ {a[15:0], a[31:16]} ^ 32'h5a5a_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive icache responses, observe and score, then advance to the next negedge.
   task automatic tick();
      logic [31:0] nxt;
      exp_t        e;
      int          due;
      inst_addr_ok = rand_ok ? 1'($urandom_range(1, 0)) : 1'b1;
      if (req_q.size() != 0 && req_q[0].due <= cyc) begin
         inst_data_ok = 1'b1;
         inst_rdata   = mem_word(req_q[0].addr);
         void'(req_q.pop_front());
      end else begin
         inst_data_ok = 1'b0;
         inst_rdata   = $urandom;
      end
      #1;
      if (fs_to_ds_valid && ds_allowin) begin
         chk("entry_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("id_pc", fs_pc, e.pc);
            chk("id_inst", fs_inst, e.inst);
            chk("id_excp", 32'(fs_excp), 32'(e.excp));
            if (pops == 0) first_pc = fs_pc;
            last_pc = fs_pc;
            if (fs_excp) adef_seen++;
            pops++;
         end
      end
      nxt = redirect_valid ? redirect_pc : model_pc;
      if (redirect_valid) begin
         chk("redirect_hides_head", 32'(fs_to_ds_valid), 32'd0);
         exp_q.delete();
         if (nxt[1:0] != 2'b00) exp_q.push_back('{nxt, 32'h0, 1'b1});
      end
      if (nxt[1:0] != 2'b00) chk("adef_no_request", 32'(inst_valid), 32'd0);
      if (fetch_hold) chk("hold_no_request", 32'(inst_valid), 32'd0);
      if (inst_valid && inst_addr_ok) begin
         chk("fetch_addr", inst_addr, nxt);
         due = cyc + int'($urandom_range(lat_max, lat_min));
         if (due < last_due) due = last_due;
         last_due = due;
         req_q.push_back('{inst_addr, due});
         exp_q.push_back('{nxt, mem_word(nxt), 1'b0});
         model_pc = nxt + 32'd4;
      end else begin
         model_pc = nxt;
      end
      chk("credit_bound", 32'(exp_q.size() <= QD), 32'd1);
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      tick();
      redirect_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      fetch_hold     = 1'b0;
      ds_allowin     = 1'b1;
      inst_addr_ok   = 1'b0;
      inst_data_ok   = 1'b0;
      inst_rdata     = 32'h0;
      req_q.delete();
      exp_q.delete();
      last_due = 0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      #1;
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst_addr", inst_addr, RESET_PC);
      chk("rst_fs_valid", 32'(fs_to_ds_valid), 32'd0);
      chk("rst_fs_pc", fs_pc, 32'h0);
      chk("rst_fs_inst", fs_inst, 32'h0);
      chk("rst_fs_excp", 32'(fs_excp), 32'd0);
      reset    = 1'b0;
      model_pc = RESET_PC;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Steady streaming, two-cycle latency
      do_reset();
      pops = 0;
      run(20);
      chk("t1_first_pc", first_pc, RESET_PC);
      chk("t1_rate", 32'(pops >= 16), 32'd1);
      chk("t1_in_flight", 32'(req_q.size()), 32'd2);

      // ID backpressure fills the queue exactly, then drains in order
      ds_allowin = 1'b0;
      run(20);
      chk("t2_held", 32'(exp_q.size()), 32'(QD));
      chk("t2_head_valid", 32'(fs_to_ds_valid), 32'd1);
      chk("t2_no_in_flight", 32'(req_q.size()), 32'd0);
      ds_allowin = 1'b1;
      pops = 0;
      run(10);
      chk("t2_drain", 32'(pops >= 6), 32'd1);

      // Three in flight, redirect drops them all
      lat_min = 3;
      lat_max = 3;
      run(10);
      chk("t3_in_flight", 32'(req_q.size()), 32'd3);
      do_redirect(32'h1c001000);
      #1;
      chk("t3_queue_empty", 32'(fs_to_ds_valid), 32'd0);
      pops = 0;
      run(12);
      chk("t3_first_pc", first_pc, 32'h1c001000);

      // Misaligned redirect raises ADEF and stops fetch until the next redirect
      lat_min = 2;
      lat_max = 2;
      run(6);
      adef_seen = 0;
      pops = 0;
      do_redirect(32'h1c002002);
      run(10);
      chk("t4_adef_seen", 32'(adef_seen), 32'd1);
      chk("t4_adef_pc", last_pc, 32'h1c002002);
      chk("t4_queue_empty", 32'(fs_to_ds_valid), 32'd0);
      do_redirect(32'h1c003000);
      pops = 0;
      run(8);
      chk("t4_recover_pc", first_pc, 32'h1c003000);

      // fetch_hold: in-flight responses still arrive, redirect still flushes
      fetch_hold = 1'b1;
      run(6);
      chk("t5_drained", 32'(exp_q.size()), 32'd0);
      chk("t5_no_in_flight", 32'(req_q.size()), 32'd0);
      fetch_hold = 1'b0;
      ds_allowin = 1'b0;
      run(2);
      fetch_hold = 1'b1;
      run(4);
      chk("t5_queued", 32'(fs_to_ds_valid), 32'd1);
      do_redirect(32'h1c004000);
      #1;
      chk("t5_flushed", 32'(fs_to_ds_valid), 32'd0);
      ds_allowin = 1'b1;
      run(3);
      fetch_hold = 1'b0;
      pops = 0;
      run(10);
      chk("t5_first_pc", first_pc, 32'h1c004000);

      // Redirect every cycle with random acceptance and latency
      rand_ok = 1'b1;
      lat_min = 1;
      lat_max = 3;
      run(5);
      for (int i = 0; i < 8; i++) do_redirect(32'h1c010000 + 32'(i) * 32'h40);
      pops = 0;
      run(40);
      chk("t6_first_pc", first_pc, 32'h1c0101c0);
      chk("t6_progress", 32'(pops >= 5), 32'd1);

      // Reset in the middle of traffic restarts at RESET_PC
      rand_ok = 1'b0;
      lat_min = 2;
      lat_max = 2;
      do_reset();
      pops = 0;
      run(10);
      chk("t7_first_pc", first_pc, RESET_PC);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
